// File: rtl/bit_serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Optional subtract mode is enabled by defining BIT_SERIAL_ADDER_SUB_EN.
package bit_serial_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/bit_serial_adder_if.sv
// Start/busy/done handshake and operand/result bus for bit_serial_adder.
// The sub signal exists only when BIT_SERIAL_ADDER_SUB_EN is defined.
interface bit_serial_adder_if
  import bit_serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef BIT_SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

`ifdef BIT_SERIAL_ADDER_SUB_EN
  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, overflow
  );
  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, overflow
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow
  );
  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow
  );
`endif

endinterface

// File: rtl/bit_serial_adder_fa_cell.sv
// Combinational 1-bit full adder used as the bit-serial adder's only arithmetic cell.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: A + B + cin one bit per clock, LSB first, through one fa_cell.
// Defining BIT_SERIAL_ADDER_SUB_EN adds a sub input selecting A - B.
module bit_serial_adder
  import bit_serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  bit_serial_adder_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             c_msb_in;
  logic             cout_q;
  logic             ovf_q;
  logic             done_q;
  logic             load;
  logic             last_bit;
  logic             b_inv;
  logic             carry_init;
  logic             fa_s;
  logic             fa_co;

  fa_cell u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Subtract is A + ~B + 1, so sub overrides cin with a forced carry-in.
  always_comb begin
    b_inv      = 1'b0;
    carry_init = bus.cin;
`ifdef BIT_SERIAL_ADDER_SUB_EN
    if (bus.sub) begin
      b_inv      = 1'b1;
      carry_init = 1'b1;
    end
`endif
  end

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN:     if (last_bit) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      sum_q    <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == FIN);
      case (state_q)
        IDLE: begin
          if (load) begin
            a_sh  <= bus.a;
            b_sh  <= b_inv ? ~bus.b : bus.b;
            carry <= carry_init;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {fa_s, res_sh[WIDTH-1:1]};
          carry  <= fa_co;
          cnt    <= last_bit ? '0 : cnt + CNT_W'(1);
          if (last_bit) c_msb_in <= carry;
        end
        FIN: begin
          sum_q  <= res_sh;
          cout_q <= carry;
          ovf_q  <= c_msb_in ^ carry;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed self-checking bench for bit_serial_adder (WIDTH=8).
module tb_bit_serial_adder;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bit_serial_adder_if #(.WIDTH(W)) bus ();

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Pulse start for one accepting edge, then scramble the operands.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
`ifdef BIT_SERIAL_ADDER_SUB_EN
    bus.sub   = sub;
`endif
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 8'hC3;
    bus.b     = 8'h3C;
    bus.cin   = ~cin;
`ifdef BIT_SERIAL_ADDER_SUB_EN
    bus.sub   = ~sub;
`endif
  endtask

  // Entered at the negedge after the accepting edge; 'skip' cycles already elapsed.
  task automatic wait_result(input string tag, input int skip, input logic [W-1:0] exp_sum,
                             input logic exp_cout, input logic exp_ovf);
    int busy_n = 0;
    int n      = 0;
    int both   = 0;
    int moved  = 0;
    logic [W-1:0] held = bus.sum;
    while (!bus.done && n < 40) begin
      if (bus.busy) busy_n++;
      if (bus.sum !== held) moved++;
      @(negedge clk);
      n++;
      if (bus.busy && bus.done) both++;
    end
    check({tag, "_timeout"}, (n < 40), 1);
    check({tag, "_busy_cycles"}, busy_n, W - skip);
    check({tag, "_latency"}, n, W + 1 - skip);
    check({tag, "_sum_held"}, moved, 0);
    check({tag, "_busy_and_done"}, both, 0);
    check({tag, "_sum"}, bus.sum, exp_sum);
    check({tag, "_cout"}, bus.cout, exp_cout);
    check({tag, "_ovf"}, bus.overflow, exp_ovf);
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
`ifdef BIT_SERIAL_ADDER_SUB_EN
    bus.sub   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    check("rst_ovf", bus.overflow, 0);
    rst = 1'b0;

    launch(8'h0F, 8'h01, 1'b0, 1'b0);
    check("op1_busy_next", bus.busy, 1);
    wait_result("op1", 0, 8'h10, 1'b0, 1'b0);

    launch(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_result("op2", 0, 8'h00, 1'b1, 1'b0);

    launch(8'h7F, 8'h01, 1'b0, 1'b0);
    wait_result("op3", 0, 8'h80, 1'b0, 1'b1);

    launch(8'h00, 8'h00, 1'b1, 1'b0);
    wait_result("op4", 0, 8'h01, 1'b0, 1'b0);

    // Start pulse with new operands during RUN must be ignored.
    launch(8'h12, 8'h34, 1'b0, 1'b0);
    @(negedge clk);
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_result("op5", 2, 8'h46, 1'b0, 1'b0);
    dones = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("op5_extra_done", dones, 0);

    // Reset during RUN cycle 4 aborts with no done.
    launch(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_sum", bus.sum, 0);
    check("abort_cout", bus.cout, 0);
    check("abort_done", bus.done, 0);
    dones = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    check("abort_quiet", dones, 0);

    launch(8'h01, 8'h01, 1'b0, 1'b0);
    wait_result("op6", 0, 8'h02, 1'b0, 1'b0);

`ifdef BIT_SERIAL_ADDER_SUB_EN
    launch(8'h05, 8'h07, 1'b0, 1'b1);
    wait_result("sub1", 0, 8'hFE, 1'b0, 1'b0);
    launch(8'h80, 8'h01, 1'b1, 1'b1);
    wait_result("sub2", 0, 8'h7F, 1'b1, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Sequential adder that computes A + B + cin one bit per clock, LSB first.
- Built around a single 1-bit full-adder cell; keeps a carry flip-flop between cycles.
- Sits upstream of and around the full-adder stage: it feeds operand bits to the cell and consumes its sum and carry outputs.
- Trades latency (WIDTH cycles) for area; provides a start/busy/done handshake to the surrounding control logic.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; sampled only when not busy.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while the serial computation runs.
- done  output  1  one-cycle pulse when a result becomes valid.
- sum  output  WIDTH  result register; holds the last completed result.
- cout  output  1  carry out of the MSB for the last result.
- overflow  output  1  signed overflow for the last result (carry into MSB XOR cout).

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values (all outputs and state): FSM=IDLE; busy=0; done=0; sum=0; cout=0; overflow=0; shift registers=0; carry=0; counter=0.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - On start=1: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0; go to RUN.
  - busy is high from the next cycle.
- RUN, each cycle:
  - The cell adds a_sh[0], b_sh[0] and carry.
  - The cell's sum bit is shifted into the MSB of res_sh (shift right).
  - a_sh and b_sh shift right; carry<=cell carry; cnt++.
  - When cnt==WIDTH-1 (the last bit):
    - Also record c_msb_in = the carry entering that bit.
    - Go to FIN.
- FIN (one cycle):
  - Updates sum<=res_sh, cout<=carry, overflow<=c_msb_in^carry.
  - done=1 in the same cycle these registered outputs become visible.
  - Next state IDLE.
- Latency: with start accepted at edge 0, busy is high for WIDTH cycles and done is high in the cycle after edge WIDTH+1. Throughput is one op per WIDTH+2 cycles.
- done is registered: high for exactly one cycle per operation, never high while busy.
- sum, cout and overflow change only in FIN. They hold their previous values throughout RUN and IDLE.
- start while busy or in FIN: ignored. It is not queued, and a, b and cin are not re-sampled.
- a, b and cin may change freely after the start cycle.
- Reset mid-operation: aborts immediately. Next cycle all outputs are at their reset values and no done is issued.
- Counter width: clog2(WIDTH) bits, sufficient for values 0..WIDTH-1.
- Wrap-around: sum is modulo 2^WIDTH. The carry past the MSB appears only on cout.

Optional Feature:
- Macro: BIT_SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured on accepted start.
  - When sub=1: B is loaded as ~b and carry is loaded as 1, so the result is A - B. cin is ignored.
  - cout=1 means no borrow; overflow is the signed subtract overflow.
- Not defined: no sub port; behaviour is add-only exactly as above.

Decomposition:
- Shared package bit_serial_pkg:
  - FSM state enum (IDLE, RUN, FIN).
  - Default WIDTH constant.
- One natural sub-module: fa_cell (1-bit full adder: inputs x, y, ci; outputs s, co).
  - Instantiated once, combinational, in the RUN datapath.

Test Plan (WIDTH=8):
- a=0x0F, b=0x01, cin=0, start pulse -> busy for 8 cycles; done pulse; sum=0x10, cout=0, overflow=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0.
- a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Start 0x12+0x34. Pulse start with 0xFF+0xFF mid-RUN -> ignored; result sum=0x46, single done pulse.
- Start 0xAA+0x55. Assert rst at RUN cycle 4 -> next cycle busy=0, sum=0, cout=0; no done. Then new op 0x01+0x01 -> sum=0x02.
- With BIT_SERIAL_ADDER_SUB_EN: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, overflow=0. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, overflow=1.
